// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer and its synchronizer.
//   db_state_t     : qualification FSM state encoding
//   DB_SYNC_STAGES : number of flops in the pin synchronizer
package debounce_pkg;

  localparam int unsigned DB_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin level.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset, clears both flops
//   d     : raw asynchronous input
//   q     : synchronized output (last flop)
module sync_2ff
  import debounce_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  // stage_q[0] is the metastability-catching flop, the MSB is the clean sample.
  logic [DB_SYNC_STAGES-1:0] stage_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DB_SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_q[DB_SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button/switch level into the system clock domain.
// Optional feature macro: BUTTON_DEBOUNCER_TOGGLE_EN (builds the toggle register;
// otherwise toggle is tied to 0).
// Parameters:
//   STABLE_CYCLES : consecutive synchronized samples needed to accept a new level (2..65535)
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   btn_in : raw asynchronous pin level
//   level  : debounced level
//   rise   : one-cycle pulse on level 0->1
//   fall   : one-cycle pulse on level 1->0
//   toggle : flips once per rise (feature build only)
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  // Entering WAIT already accounts for one matching sample, so the last count is N-2.
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 2);

  logic            s;
  db_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_q <= IDLE_LOW;
          end else if (cnt_q == CntLast) begin
            state_q <= IDLE_HIGH;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_q <= IDLE_HIGH;
          end else if (cnt_q == CntLast) begin
            state_q <= IDLE_LOW;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE_LOW;
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_q ^ rise_q;
    end
  end

  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with STABLE_CYCLES = 4.
// Stimulus pushes the hand-computed expected {level,rise,fall,toggle} for the edge
// that follows each input update; a monitor pops and compares 1 ns after every edge.
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  localparam bit TogEn = 1'b1;
`else
  localparam bit TogEn = 1'b0;
`endif

  logic clock;
  logic reset;
  logic btn_in;
  logic level;
  logic rise;
  logic fall;
  logic toggle;

  typedef struct {
    logic [3:0] v;
    string      name;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  bit   tog_model;

  button_debouncer #(
    .STABLE_CYCLES (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .btn_in (btn_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .toggle (toggle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at a falling edge: drive btn, queue the outputs expected after the next edge.
  task automatic step(input logic b, input logic l, input logic r, input logic f,
                      input string name, input int idx);
    exp_t e;
    btn_in = b;
    e.v    = {l, r, f, TogEn & tog_model};
    e.name = name;
    e.idx  = idx;
    sb.push_back(e);
    @(negedge clock);
  endtask

  // Idle low -> press: edge 0 captures the 1, level/rise on edge 5, toggle flips on edge 6.
  task automatic press(input string name);
    for (int i = 0; i < 10; i++) begin
      if (i == 6) tog_model = ~tog_model;
      step(1'b1, i >= 5, i == 5, 1'b0, name, i);
    end
  endtask

  // Idle high -> release: level drops and fall pulses on edge 5.
  task automatic release_btn(input string name);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i < 5, 1'b0, i == 5, name, i);
    end
  endtask

  task automatic direct_check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {level, rise, fall, toggle};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Monitor: one comparison per queued expectation.
  initial begin
    exp_t e;
    logic [3:0] got;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {level, rise, fall, toggle};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s[%0d] {level,rise,fall,toggle} got=%b exp=%b",
                   e.name, e.idx, got, e.v);
        end
      end
    end
  end

  initial begin
    int bounce[6];
    bounce = '{1, 1, 0, 1, 1, 0};
    checks    = 0;
    errors    = 0;
    tog_model = 1'b0;
    reset     = 1'b0;
    btn_in    = 1'b0;

    repeat (3) @(negedge clock);
    direct_check("reset_hold", 4'b0000);
    reset = 1'b1;

    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "idle", i);

    press("clean_press");
    release_btn("release");

    for (int i = 0; i < 6; i++) step(bounce[i] != 0, 1'b0, 1'b0, 1'b0, "bounce", i);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_tail", i);

    // Reach WAIT_HIGH (edge 2) and stop one cycle into qualification.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "pre_reset", i);
    reset = 1'b0;
    #1;
    direct_check("reset_async", 4'b0000);
    tog_model = 1'b0;
    @(negedge clock);
    direct_check("reset_mid", 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    press("press_after_reset");

    release_btn("rel1");
    press("press2");
    release_btn("rel2");
    press("press3");
    release_btn("rel3");

    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
